// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the fetch port, data port and shared memory port of mem_arbiter.
// Ports: i_* fetch requester, d_* data requester, mem_* single shared memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  // fetch requester
  logic        i_req;
  logic [63:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_ack;
  // data requester
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_tam;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;
  // shared memory port
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_tam;
  logic [63:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_tam, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_we, mem_tam
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_tam, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_we, mem_tam
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between fetch and data requesters.
// Latency: request sampled in IDLE at cycle 0 -> ack pulse in cycle MEM_LAT+2; one transaction in flight.
// Backpressure: requests are only sampled in IDLE; a requester simply holds req until its ack pulse.
// Ports: clk, rst_n (sync, active-low), bus (mem_arbiter_if.slave: i_*, d_*, mem_*), busy (FSM not IDLE).
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2   // read latency in cycles, 1..15
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;   // 1 = data port won last, 0 = fetch port won last
  logic        win_d;        // winner of the transaction in flight
  logic        we_q;         // latched store flag (always 0 for fetches)
  logic        grant_vld;
  logic        grant_d;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_vld = bus.i_req | bus.d_req;
    grant_d   = bus.d_req & (~bus.i_req | ~last_grant);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    bus.mem_we = (state == ISSUE) & win_d & we_q;
    bus.i_ack  = (state == DONE) & ~win_d;
    bus.d_ack  = (state == DONE) & win_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      last_grant    <= 1'b1;
      win_d         <= 1'b0;
      we_q          <= 1'b0;
      bus.mem_addr  <= 64'd0;
      bus.mem_wdata <= 64'd0;
      bus.mem_tam   <= 2'b00;
      bus.i_rdata   <= 64'd0;
      bus.d_rdata   <= 64'd0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            win_d      <= grant_d;
            last_grant <= grant_d;
            if (grant_d) begin
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_tam   <= bus.d_tam;
              we_q          <= bus.d_we;
            end else begin
              // fetches are always dword reads, whatever the data port shows
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wdata <= 64'd0;
              bus.mem_tam   <= 2'b00;
              we_q          <= 1'b0;
            end
          end
        end
        ISSUE: cnt <= 4'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - 4'd1;
          // The read word is sampled on the edge that enters DONE, exactly
          // MEM_LAT cycles after issue, so it is visible alongside the ack.
          if (cnt == 4'd1) begin
            if (!win_d)     bus.i_rdata <= bus.mem_rdata;
            else if (!we_q) bus.d_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a scoreboard of expected acks.
// Latency: checks ack arrives MEM_LAT+2 cycles after the sampling cycle.
// Backpressure: n/a (stimulus holds or drops requests per scenario).
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic        is_d;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h40) return 64'h0000_0000_0050_0093;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  assign bus.mem_rdata = mem_word(bus.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [63:0] rdata, input int at);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  // Ack monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.i_ack || bus.d_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_i_ack", 64'(bus.i_ack), 64'd0);
        chk("unexpected_d_ack", 64'(bus.d_ack), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_kind", 64'(bus.d_ack), 64'(e.is_d));
        chk("ack_loser", 64'(e.is_d ? bus.i_ack : bus.d_ack), 64'd0);
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("ack_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
      end
    end
  end

  // Follows one transaction from ISSUE to the IDLE cycle after DONE, scrambling
  // the requester inputs after grant; drop also releases the request lines.
  task automatic watch(input logic [63:0] ea, input logic [63:0] ew, input logic [1:0] et,
                       input logic ewe, input bit drop);
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_tam", 64'(bus.mem_tam), 64'(et));
      chk("mem_we", 64'(bus.mem_we), 64'((k == 1) && ewe));
      chk("busy", 64'(busy), 64'd1);
      if (ewe) chk("mem_wdata", bus.mem_wdata, ew);
      if (k == 1) begin
        if (drop) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
        end
        bus.i_addr  = 64'h300;
        bus.d_addr  = 64'h300;
        bus.d_wdata = ~bus.d_wdata;
        bus.d_tam   = ~bus.d_tam;
        bus.d_we    = ~bus.d_we;
      end
    end
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = 64'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_tam   = 2'b00;
    bus.d_addr  = 64'd0;
    bus.d_wdata = 64'd0;
    repeat (3) step();

    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_i_ack", 64'(bus.i_ack), 64'd0);
    chk("rst_d_ack", 64'(bus.d_ack), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_i_rdata", bus.i_rdata, 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst_mem_tam", 64'(bus.mem_tam), 64'd0);
    rst_n = 1'b1;
    step();

    // fetch 0x40, request dropped after grant, data port showing store junk
    bus.i_req   = 1'b1;
    bus.i_addr  = 64'h40;
    bus.d_we    = 1'b1;
    bus.d_tam   = 2'b11;
    bus.d_wdata = 64'h1234;
    push(1'b0, 64'h0050_0093, cyc + LAT + 2);
    watch(64'h40, 64'd0, 2'b00, 1'b0, 1'b1);
    chk("i_rdata_hold", bus.i_rdata, 64'h0050_0093);

    // data load from 0x200, address moves to 0x300 after grant
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_tam  = 2'b10;
    bus.d_addr = 64'h200;
    push(1'b1, mem_word(64'h200), cyc + LAT + 2);
    watch(64'h200, 64'd0, 2'b10, 1'b0, 1'b0);

    // store: d_rdata must keep the previous load result
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_tam   = 2'b01;
    bus.d_addr  = 64'h100;
    bus.d_wdata = 64'hDEAD_BEEF;
    push(1'b1, mem_word(64'h200), cyc + LAT + 2);
    watch(64'h100, 64'hDEAD_BEEF, 2'b01, 1'b1, 1'b1);
    chk("i_rdata_after_d", bus.i_rdata, 64'h0050_0093);

    // tie held continuously: last grant was data, so I, D, I
    begin
      int t0;
      t0 = cyc;
      bus.i_req  = 1'b1;
      bus.i_addr = 64'h1000;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_tam  = 2'b00;
      bus.d_addr = 64'h2000;
      push(1'b0, mem_word(64'h1000), t0 + LAT + 2);
      push(1'b1, mem_word(64'h2000), t0 + 2 * (LAT + 3) - 1);
      push(1'b0, mem_word(64'h1000), t0 + 3 * (LAT + 3) - 1);
      for (int k = 1; k <= 3 * (LAT + 3); k++) begin
        step();
        if (k == LAT + 3 || k == 2 * (LAT + 3)) chk("tie_idle_busy", 64'(busy), 64'd0);
        if (k == LAT + 4) begin
          chk("tie_d_issue_addr", bus.mem_addr, 64'h2000);
          chk("tie_d_issue_we", 64'(bus.mem_we), 64'd0);
        end
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      step();
    end

    // reset in the middle of a fetch: aborted, and fetch wins the next tie
    bus.i_req  = 1'b1;
    bus.i_addr = 64'h80;
    step();
    bus.i_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mem_we", 64'(bus.mem_we), 64'd0);
    chk("abort_i_ack", 64'(bus.i_ack), 64'd0);
    chk("abort_d_ack", 64'(bus.d_ack), 64'd0);
    chk("abort_i_rdata", bus.i_rdata, 64'd0);
    chk("abort_d_rdata", bus.d_rdata, 64'd0);
    chk("abort_mem_addr", bus.mem_addr, 64'd0);
    rst_n      = 1'b1;
    bus.i_req  = 1'b1;
    bus.i_addr = 64'h40;
    bus.d_req  = 1'b1;
    bus.d_addr = 64'h500;
    push(1'b0, 64'h0050_0093, cyc + LAT + 2);
    watch(64'h40, 64'd0, 2'b00, 1'b0, 1'b1);

    repeat (4) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
